// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI definitions: serializer states, register map, STATUS bits
//
// Contents:
//   midi_tx_state_t  serializer state encoding (IDLE, START, DATA, STOP)
//   MIDI_REG_CTRL    CTRL/STATUS register address
//   MIDI_REG_DATA    TXDATA register address
//   STAT_*           bit positions inside the STATUS byte
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } midi_tx_state_t;

  localparam logic [7:0] MIDI_REG_CTRL = 8'h00;
  localparam logic [7:0] MIDI_REG_DATA = 8'h01;

  localparam int STAT_IRQ_EN   = 0;
  localparam int STAT_BUSY     = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_EMPTY    = 3;
  localparam int STAT_OVERFLOW = 4;

endpackage

// File: rtl/midi_fifo.sv
// rtl/midi_fifo.sv - synchronous show-ahead FIFO for MIDI byte queues
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset; empties the FIFO
//   push_i   write din_i (dropped when full unless pop_i is also accepted)
//   din_i    write data
//   pop_i    remove the head entry (ignored when empty)
//   dout_o   head entry, valid whenever empty_o is 0
//   full_o   DEPTH entries held
//   empty_o  no entries held
//   count_o  number of entries held, log2(DEPTH)+1 bits
module midi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a push while full is
  // still accepted when it coincides with an accepted pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - Wishbone MIDI transmitter: byte FIFO plus 8N1 serializer
//
// Ports:
//   wb_clk_i   sample clock
//   wb_rst_i   asynchronous active-low reset
//   wb_addr_i  register address (0x00 CTRL/STATUS, 0x01 TXDATA)
//   wb_dat_i   write data
//   wb_dat_o   registered read data, valid with wb_ack_o
//   wb_stb_i   strobe
//   wb_we_i    write enable
//   wb_ack_o   single-cycle acknowledge
//   midi_out   serial MIDI output, idles high
//   irq_o      level interrupt: irq_en and FIFO empty and serializer idle
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       midi_out,
  output logic       irq_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  midi_tx_state_t state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           midi_out_q, midi_out_d;
  logic           irq_q, irq_d;
  logic           ack_q, ack_d;
  logic [7:0]     dat_q, dat_d;
  logic           irq_en_q, irq_en_d;
  logic           ovf_q, ovf_d;

  logic           access, wr_ctrl, wr_data, rd_any;
  logic           bit_end, busy;
  logic [7:0]     status;
  logic           fifo_pop, fifo_full, fifo_empty, fifo_at_cap;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;

  // An access is taken only while no ack is outstanding, so a held strobe
  // yields an ack every other cycle.
  assign access  = wb_stb_i && !ack_q;
  assign wr_ctrl = access && wb_we_i && (wb_addr_i == MIDI_REG_CTRL);
  assign wr_data = access && wb_we_i && (wb_addr_i == MIDI_REG_DATA);
  assign rd_any  = access && !wb_we_i;

  assign bit_end     = (tick_q == TW'(CLKS_PER_BIT - 1));
  assign fifo_at_cap = (fifo_count == CW'(FIFO_DEPTH));

  midi_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_i),
    .push_i  (wr_data),
    .din_i   (wb_dat_i),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Serializer: state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      midi_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      midi_out_q <= midi_out_d;
    end
  end

  // Serializer: next state. STOP reloads directly into START so queued
  // bytes go out with no idle bit between frames.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tick_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          tick_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer: outputs. The pin level is registered from the current state,
  // which puts the start bit two edges after the accepting write.
  always_comb begin
    busy       = (state_q != IDLE);
    midi_out_d = 1'b1;
    case (state_q)
      START:   midi_out_d = 1'b0;
      DATA:    midi_out_d = shift_q[0];
      default: midi_out_d = 1'b1;
    endcase
  end

  // Bus registers, status and interrupt.
  always_comb begin
    status                = 8'h00;
    status[STAT_IRQ_EN]   = irq_en_q;
    status[STAT_BUSY]     = busy;
    status[STAT_FULL]     = fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_OVERFLOW] = ovf_q;

    ack_d    = access;
    dat_d    = dat_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    irq_d    = irq_en_q && fifo_empty && (state_q == IDLE);

    if (rd_any) dat_d = (wb_addr_i == MIDI_REG_CTRL) ? status : 8'h00;
    if (wr_ctrl) begin
      irq_en_d = wb_dat_i[0];
      if (wb_dat_i[4]) ovf_d = 1'b0;
    end
    if (wr_data && fifo_at_cap && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign midi_out = midi_out_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - self-checking bench for midi_tx with a serial line decoder
module tb_midi_tx;

  localparam int CPB   = 8;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] dat_in;
  logic [7:0] dat_out;
  logic       stb;
  logic       we;
  logic       ack;
  logic       midi_out;
  logic       irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  midi_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wb_addr_i (addr),
    .wb_dat_i  (dat_in),
    .wb_dat_o  (dat_out),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_ack_o  (ack),
    .midi_out  (midi_out),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples the middle of every bit of each frame it sees.
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         frame_err = 0;
  int         dec_start;
  logic [7:0] dec_byte;
  bit         dec_ok;
  bit         dec_abort;

  initial begin : decoder
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && midi_out === 1'b0) begin
        dec_start = cyc;
        dec_byte  = 8'h00;
        dec_ok    = 1'b1;
        dec_abort = 1'b0;
        for (int t = 1; t < FRAME; t++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            dec_abort = 1'b1;
            break;
          end
          if (t == CPB / 2 && midi_out !== 1'b0) dec_ok = 1'b0;
          if (t >= CPB && t < 9 * CPB && (t % CPB) == CPB / 2) dec_byte[(t / CPB) - 1] = midi_out;
          if (t == 9 * CPB + CPB / 2 && midi_out !== 1'b1) dec_ok = 1'b0;
        end
        if (!dec_abort) begin
          if (!dec_ok) frame_err++;
          rx_q.push_back(dec_byte);
          rx_start_q.push_back(dec_start);
        end
      end
    end
  end

  // Expected line level k cycles after the start-bit falling edge.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    if (k < CPB)          return 1'b0;
    else if (k < 9 * CPB) return b[(k - CPB) / CPB];
    else                  return 1'b1;
  endfunction

  task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rdata);
    bit acked = 1'b0;
    rdata  = 8'h00;
    stb    = 1'b1;
    we     = w;
    addr   = a;
    dat_in = d;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack === 1'b1) begin
        acked = 1'b1;
        rdata = dat_out;
      end
    end
    stb = 1'b0;
    we  = 1'b0;
    if (!acked) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bus_timeout addr=%02h ack=%b required=1", a, ack);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] unused_rd;
    bus_xfer(1'b1, a, d, unused_rd);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus_xfer(1'b0, a, 8'h00, d);
  endtask

  task automatic do_reset();
    stb    = 1'b0;
    we     = 1'b0;
    addr   = 8'h00;
    dat_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] r;
    stb    = 1'b0;
    we     = 1'b0;
    addr   = 8'h00;
    dat_in = 8'h00;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (midi_out !== 1'b1) begin n_fail++; $display("FAIL reset_midi_out got=%b required=1", midi_out); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b required=0", ack); end
    n_cmp++; if (dat_out !== 8'h00) begin n_fail++; $display("FAIL reset_dat_o got=%02h required=00", dat_out); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b required=0", irq); end
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h08) begin n_fail++; $display("FAIL reset_status got=%02h required=08", r); end
  endtask

  task automatic test_bus();
    logic [7:0] r;
    logic       exp_ack;
    rd(8'h05, r);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL bus_rd_unused got=%02h required=00", r); end
    rd(8'h01, r);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL bus_rd_txdata got=%02h required=00", r); end
    wr(8'h05, 8'hFF);
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h08) begin n_fail++; $display("FAIL bus_wr_unused_status got=%02h required=08", r); end
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bus_ack_pulse got=%b required=1", ack); end
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL bus_ack_single got=%b required=0", ack); end
    stb  = 1'b1;
    we   = 1'b0;
    addr = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_ack = (i % 2 == 0);
      n_cmp++; if (ack !== exp_ack) begin n_fail++; $display("FAIL bus_held_stb cycle=%0d got=%b required=%b", i, ack, exp_ack); end
    end
    stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b = 8'hDE;
    logic [7:0] r;
    int         first_bad = -1;
    logic       bad_val = 1'b0;
    rx_q.delete();
    rx_start_q.delete();
    wr(8'h01, b);
    @(negedge clk);
    n_cmp++; if (midi_out !== 1'b1) begin n_fail++; $display("FAIL single_e1_high got=%b required=1", midi_out); end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (first_bad < 0 && midi_out !== exp_line(b, k)) begin
        first_bad = k;
        bad_val   = midi_out;
      end
    end
    n_cmp++; if (first_bad != -1) begin n_fail++; $display("FAIL single_wave first_bad_cycle=%0d got=%b required=%b", first_bad, bad_val, exp_line(b, first_bad)); end
    @(negedge clk);
    n_cmp++; if (midi_out !== 1'b1) begin n_fail++; $display("FAIL single_idle_after got=%b required=1", midi_out); end
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h08) begin n_fail++; $display("FAIL single_status got=%02h required=08", r); end
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== b) begin n_fail++; $display("FAIL single_decode count=%0d required=1 byte=%02h required=%02h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h90;
    exp_b[1] = 8'h3C;
    exp_b[2] = 8'h7F;
    rx_q.delete();
    rx_start_q.delete();
    frame_err = 0;
    for (int i = 0; i < 3; i++) wr(8'h01, exp_b[i]);
    repeat (3 * FRAME + 20) @(negedge clk);
    n_cmp++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL b2b_count got=%0d required=3", rx_q.size()); end
    if (rx_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d got=%02h required=%02h", i, rx_q[i], exp_b[i]); end
      end
      n_cmp++; if (rx_start_q[1] - rx_start_q[0] != FRAME || rx_start_q[2] - rx_start_q[1] != FRAME) begin n_fail++; $display("FAIL b2b_gap got=%0d,%0d required=%0d", rx_start_q[1] - rx_start_q[0], rx_start_q[2] - rx_start_q[1], FRAME); end
      n_cmp++; if (rx_start_q[2] + FRAME - rx_start_q[0] != 3 * FRAME) begin n_fail++; $display("FAIL b2b_total got=%0d required=%0d", rx_start_q[2] + FRAME - rx_start_q[0], 3 * FRAME); end
    end
    n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL b2b_framing got=%0d required=0", frame_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] sent[10];
    logic [7:0] exp_q[$];
    logic [7:0] r;
    int         first_bad = -1;
    do_reset();
    rx_q.delete();
    rx_start_q.delete();
    frame_err = 0;
    for (int i = 0; i < 10; i++) sent[i] = 8'($urandom);
    // One byte moves into the serializer at once; DEPTH more fit the queue.
    for (int i = 0; i < 10; i++) if (i < DEPTH + 1) exp_q.push_back(sent[i]);
    for (int i = 0; i < 10; i++) wr(8'h01, sent[i]);
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h16) begin n_fail++; $display("FAIL ovf_status_full got=%02h required=16", r); end
    wr(8'h00, 8'h10);
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h06) begin n_fail++; $display("FAIL ovf_clear got=%02h required=06", r); end
    repeat ((DEPTH + 1) * FRAME + 40) @(negedge clk);
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_tx_count got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (first_bad < 0 && rx_q[i] !== exp_q[i]) first_bad = i;
    n_cmp++; if (first_bad != -1) begin n_fail++; $display("FAIL ovf_tx_bytes index=%0d got=%02h required=%02h", first_bad, rx_q[first_bad], exp_q[first_bad]); end
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h08) begin n_fail++; $display("FAIL ovf_status_end got=%02h required=08", r); end
    n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL ovf_framing got=%0d required=0", frame_err); end
  endtask

  task automatic test_interrupt();
    logic [7:0] b = 8'($urandom);
    do_reset();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got=%b required=0", irq); end
    wr(8'h00, 8'h01);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enabled_idle got=%b required=1", irq); end
    wr(8'h01, b);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_at_push got=%b required=1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b required=0", irq); end
    repeat (FRAME) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_end got=%b required=0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b required=1", irq); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r;
    do_reset();
    wr(8'h01, 8'h00);
    wr(8'h01, 8'($urandom));
    wr(8'h01, 8'($urandom));
    repeat (30) @(negedge clk);
    n_cmp++; if (midi_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_data got=%b required=0", midi_out); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (midi_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_async_high got=%b required=1", midi_out); end
    n_cmp++; if (ack !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs ack=%b irq=%b required=0,0", ack, irq); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    rx_start_q.delete();
    repeat (3 * FRAME + 20) @(negedge clk);
    n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_frames got=%0d required=0", rx_q.size()); end
    rd(8'h00, r);
    n_cmp++; if (r !== 8'h08) begin n_fail++; $display("FAIL rstmid_status got=%02h required=08", r); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         first_bad = -1;
    rx_q.delete();
    rx_start_q.delete();
    frame_err = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(8'h01, b);
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    repeat (6 * FRAME + 20) @(negedge clk);
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) if (first_bad < 0 && rx_q[i] !== exp_q[i]) first_bad = i;
    n_cmp++; if (first_bad != -1) begin n_fail++; $display("FAIL rand_bytes index=%0d got=%02h required=%02h", first_bad, rx_q[first_bad], exp_q[first_bad]); end
    n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL rand_framing got=%0d required=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_single();
    test_back_to_back();
    test_overflow();
    test_interrupt();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
